mux_4to1: RTL and testbench

Single-bit 4-to-1 data selector with a combinational output and a registered copy for synchronous consumers. Two select inputs (A = MSB, B = LSB) choose one of four data inputs s0..s3. It is a leaf primitive for control-path steering. The combinational path is unaffected by clock and reset, so existing combinational users see pure mux behaviour.

---
 rtl/mux_4to1.sv | 69 ++++++
 tb/tb_mux_4to1.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_4to1
//  Purpose  : Single-bit 4-to-1 data selector. Provides a purely combinational
//             output plus a registered copy of that output and a one-cycle
//             pulse that flags a change of the registered select value.
//
//  Ports    : clk      in   1  system clock, rising-edge active
//             rst      in   1  synchronous active-high reset
//             A        in   1  select MSB
//             B        in   1  select LSB
//             s0..s3   in   1  data inputs, chosen by {A,B} = 0..3
//             F        out  1  combinational mux output
//             F_q      out  1  mux output registered on rising clk
//             sel_chg  out  1  high for one cycle after a new select is sampled
//
//  Revision : 1.0  initial release
// ============================================================================
module mux_4to1 (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    input  logic s3,
    output logic F,
    output logic F_q,
    output logic sel_chg
);

    // ------------------------------------------------------------------------
    // Combinational path
    // ------------------------------------------------------------------------
    logic [1:0] sel_d;
    logic [1:0] sel_q;
    logic       f_d;
    logic       sel_chg_d;

    assign sel_d = {A, B};

    // Nested conditional operators give the simulator's natural X-merging
    // behaviour when a select bit is unknown; a case statement would instead
    // fall through to a default and hide that.
    assign F = A ? (B ? s3 : s2) : (B ? s1 : s0);

    // ------------------------------------------------------------------------
    // Registered path next-state
    // ------------------------------------------------------------------------
    assign f_d       = F;
    // Compared against the previously sampled select; sel_q resets to 00, so
    // leaving reset with sel = 00 produces no pulse.
    assign sel_chg_d = (sel_d != sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            F_q     <= 1'b0;
            sel_q   <= 2'b00;
            sel_chg <= 1'b0;
        end else begin
            F_q     <= f_d;
            sel_q   <= sel_d;
            sel_chg <= sel_chg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_4to1
//  Purpose  : Self-checking bench for mux_4to1. A behavioural model tracks the
//             expected registered outputs; a compare process checks all DUT
//             outputs on every falling edge, and the stimulus block adds
//             hand-computed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_4to1;

    logic       clk;
    logic       rst;
    logic       A;
    logic       B;
    logic [3:0] s;
    logic       F;
    logic       F_q;
    logic       sel_chg;

    int checks   = 0;
    int failures = 0;

    mux_4to1 dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .s0      (s[0]),
        .s1      (s[1]),
        .s2      (s[2]),
        .s3      (s[3]),
        .F       (F),
        .F_q     (F_q),
        .sel_chg (sel_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking helper
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: the selected data bit is simply the data vector
    // indexed by the select number; registered values are what that index
    // gave at the last rising edge.
    // ------------------------------------------------------------------------
    function automatic logic model_f(input int sel, input logic [3:0] d);
        return d[sel];
    endfunction

    int   m_prev_sel = 0;
    logic m_fq       = 1'b0;
    logic m_chg      = 1'b0;
    bit   m_valid    = 1'b0;

    always @(posedge clk) begin
        int cur;
        cur = (A ? 2 : 0) + (B ? 1 : 0);
        if (rst) begin
            m_fq       = 1'b0;
            m_chg      = 1'b0;
            m_prev_sel = 0;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            m_fq       = model_f(cur, s);
            m_chg      = (cur != m_prev_sel);
            m_prev_sel = cur;
        end
    end

    // Compare process: inputs change 3 time units after the rising edge, so
    // the falling edge sees stable inputs and settled registers.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_F",       F,       model_f((A ? 2 : 0) + (B ? 1 : 0), s));
            chk("model_F_q",     F_q,     m_fq);
            chk("model_sel_chg", sel_chg, m_chg);
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic drive(input logic a, input logic b, input logic [3:0] d);
        A = a;
        B = b;
        s = d;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        A   = 1'b0;
        B   = 1'b0;
        s   = 4'b0000;
        tick();
        tick();
        chk("reset_F_q",     F_q,     1'b0);
        chk("reset_sel_chg", sel_chg, 1'b0);
        rst = 1'b0;

        // All-zero sweep, then s0 rises
        drive(1'b0, 1'b0, 4'b0000);
        chk("zero_F", F, 1'b0);
        drive(1'b0, 1'b0, 4'b0001);
        chk("s0_F_immediate", F, 1'b1);
        tick();
        tick();
        chk("s0_F_q_two_cycles", F_q, 1'b1);
        chk("s0_no_pulse", sel_chg, 1'b0);

        // Select walk: only the matching data input high
        for (int i = 0; i < 4; i++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << i;
            drive(i[1], i[0], onehot);
            chk("walk_F_one", F, 1'b1);
            drive(i[1], i[0], 4'b0000);
            chk("walk_F_zero", F, 1'b0);
            tick();
        end

        // Isolation: unselected inputs high, selected low
        drive(1'b0, 1'b1, 4'b1101);
        chk("iso_sel01_F", F, 1'b0);
        tick();
        chk("iso_sel01_F_q", F_q, 1'b0);
        drive(1'b1, 1'b1, 4'b1000);
        chk("iso_sel11_F", F, 1'b1);
        tick();
        chk("iso_sel11_F_q", F_q, 1'b1);
        chk("iso_sel11_pulse", sel_chg, 1'b1);

        // Register latency: hold sel = 10, toggle s2 every cycle
        drive(1'b1, 1'b0, 4'b0000);
        tick();
        chk("lat_first_pulse", sel_chg, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic v;
            v = (i % 2 == 0);
            drive(1'b1, 1'b0, {1'b1, v, 1'b1, 1'b1} & 4'b1111);
            tick();
            chk("lat_F_q_prev_s2", F_q, v);
            chk("lat_no_pulse",    sel_chg, 1'b0);
        end

        // Select-change pulse after reset
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000);
        tick();
        rst = 1'b0;
        tick();
        chk("exit_reset_sel00_no_pulse", sel_chg, 1'b0);
        drive(1'b1, 1'b1, 4'b0000);
        tick();
        chk("pulse_high", sel_chg, 1'b1);
        tick();
        chk("pulse_low_1", sel_chg, 1'b0);
        tick();
        chk("pulse_low_2", sel_chg, 1'b0);

        // Select changing every cycle keeps the pulse high
        for (int i = 0; i < 4; i++) begin
            drive(i[0], ~i[0], 4'b1010);
            tick();
            chk("toggle_sel_pulse", sel_chg, 1'b1);
        end

        // Simultaneous select and data change at one edge
        drive(1'b0, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 1'b1, 4'b1000);
        tick();
        chk("simul_change_F_q", F_q, 1'b1);

        // Reset mid-operation
        drive(1'b1, 1'b1, 4'b1000);
        tick();
        chk("midrst_pre_F_q", F_q, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b1, 4'b0010);
        tick();
        chk("midrst_F_q",     F_q,     1'b0);
        chk("midrst_sel_chg", sel_chg, 1'b0);
        chk("midrst_F_tracks", F, 1'b1);
        rst = 1'b0;
        tick();
        chk("post_rst_F_q",  F_q,     1'b1);
        chk("post_rst_pulse", sel_chg, 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
